// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_arb_pkg                                           |
// | Description : Shared types for the data-memory arbiter: FSM state    |
// |               encoding, port-owner encoding and owner lookup helpers.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      CPU    = 2'd0,
      DRAIN  = 2'd1,
      COPY   = 2'd2,
      FINISH = 2'd3
   } arb_state_t;

   // Which requester currently owns a memory port
   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_RC   = 2'd2;
   localparam logic [1:0] OWN_BC   = 2'd3;

   // DRAIN keeps the CPU on the read port so its in-flight read can return
   function automatic logic [1:0] rd_owner(input arb_state_t s);
      case (s)
         CPU, DRAIN: rd_owner = OWN_CPU;
         COPY:       rd_owner = OWN_RC;
         default:    rd_owner = OWN_NONE;
      endcase
   endfunction

   // Only CPU and COPY have a writer; DRAIN and FINISH block all writes
   function automatic logic [1:0] wr_owner(input arb_state_t s);
      case (s)
         CPU:     wr_owner = OWN_CPU;
         COPY:    wr_owner = OWN_BC;
         default: wr_owner = OWN_NONE;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : dmem_arbiter_if                                        |
// | Description : Requester-side and bsram-side signals of the data      |
// |               memory arbiter. slave = arbiter view, master = the     |
// |               surrounding requesters / memory.                       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface dmem_arbiter_if #(
   parameter int AW = 13
);
   // Requesters
   logic          copy_req;
   logic          cpu_halted;
   logic [AW-1:0] cpu_rd_addr;
   logic          cpu_we;
   logic [AW-1:0] cpu_wr_addr;
   logic [15:0]   cpu_wr_data;
   logic [AW-1:0] rc_rd_addr;
   logic          rc_done;
   logic          bc_we;
   logic [AW-1:0] bc_wr_addr;
   logic [15:0]   bc_wr_data;
   logic          bc_done;
   // Memory port and status
   logic [AW-1:0] mem_rd_addr;
   logic          mem_we;
   logic [AW-1:0] mem_wr_addr;
   logic [15:0]   mem_wr_data;
   logic          cpu_rd_valid;
   logic          rc_rd_valid;
   logic          copy;
   logic          copy_go;
   logic          resume;
   logic          wdog_err;

   modport slave (
      input  copy_req, cpu_halted, cpu_rd_addr, cpu_we, cpu_wr_addr, cpu_wr_data,
      input  rc_rd_addr, rc_done, bc_we, bc_wr_addr, bc_wr_data, bc_done,
      output mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data,
      output cpu_rd_valid, rc_rd_valid, copy, copy_go, resume, wdog_err
   );

   modport master (
      output copy_req, cpu_halted, cpu_rd_addr, cpu_we, cpu_wr_addr, cpu_wr_data,
      output rc_rd_addr, rc_done, bc_we, bc_wr_addr, bc_wr_data, bc_done,
      input  mem_rd_addr, mem_we, mem_wr_addr, mem_wr_data,
      input  cpu_rd_valid, rc_rd_valid, copy, copy_go, resume, wdog_err
   );
endinterface
`default_nettype wire

// File: rtl/dmem_arb_wdog.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_arb_wdog                                          |
// | Description : Copy-window watchdog. Counts COPY cycles and flags the |
// |               cycle in which the window has lasted WDOG_CYCLES.      |
// |               Only instantiated when DMEM_ARB_WDOG_EN is defined.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmem_arb_wdog #(
   parameter int WDOG_CYCLES = 4096
) (
   input  wire logic clk,
   input  wire logic resetn,
   input  wire logic in_copy_i,
   output logic      timeout_o
);
   localparam logic [15:0] LAST_CNT = 16'(WDOG_CYCLES - 1);

   logic [15:0] cnt_q;

   // Zero outside COPY so every window starts counting from 0
   always_ff @(posedge clk) begin
      if (!resetn || !in_copy_i) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign timeout_o = in_copy_i && (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dmem_arbiter                                           |
// | Description : Owns the bsram port pair and shares it between the CPU,|
// |               the rect copy reader and the button writer. Sequences  |
// |               the per-frame window CPU -> DRAIN -> COPY -> FINISH.   |
// |               Optional watchdog: define DMEM_ARB_WDOG_EN.            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dmem_arbiter #(
   parameter int DATA_ADDR_WIDTH = 13,
   parameter int WDOG_CYCLES     = 4096
) (
   input  wire logic     clk,
   input  wire logic     resetn,
   dmem_arbiter_if.slave bus
);
   import dmem_arb_pkg::*;

   arb_state_t                 state_q, state_d;
   logic                       pending_q, rc_seen_q, bc_seen_q;
   logic                       copy_q, copy_go_q, resume_q;
   logic                       cpu_rd_valid_q, rc_rd_valid_q;
   logic                       w_wdog_hit, w_halt_ok, w_copy_done;
   logic [1:0]                 w_rd_owner, w_wr_owner;
   logic [DATA_ADDR_WIDTH-1:0] w_rd_addr, w_wr_addr;
   logic [15:0]                w_wr_data;
   logic                       w_we;

   // The 16-bit watchdog counter can only reach 65535
   if (WDOG_CYCLES < 2 || WDOG_CYCLES > 65536) begin : g_bad_wdog_cycles
      $error("dmem_arbiter: WDOG_CYCLES must be within 2..65536");
   end

   assign w_halt_ok   = (pending_q | bus.copy_req) & bus.cpu_halted;
   // A done pulse in the current cycle counts as well as a remembered one
   assign w_copy_done = (rc_seen_q | bus.rc_done) & (bc_seen_q | bus.bc_done);

`ifdef DMEM_ARB_WDOG_EN
   logic wdog_err_q;

   dmem_arb_wdog #(
      .WDOG_CYCLES (WDOG_CYCLES)
   ) u_wdog (
      .clk       (clk),
      .resetn    (resetn),
      .in_copy_i (state_q == COPY),
      .timeout_o (w_wdog_hit)
   );

   // Sticky timeout flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wdog_err_q <= 1'b0;
      end else if (w_wdog_hit) begin
         wdog_err_q <= 1'b1;
      end
   end

   assign bus.wdog_err = wdog_err_q;
`else
   assign w_wdog_hit   = 1'b0;
   assign bus.wdog_err = 1'b0;
`endif

   // Next-state decision for the copy window
   always_comb begin
      state_d = state_q;
      case (state_q)
         CPU:     if (w_halt_ok) state_d = DRAIN;
         DRAIN:   state_d = COPY;
         COPY:    if (w_wdog_hit || w_copy_done) state_d = FINISH;
         FINISH:  state_d = CPU;
         default: state_d = CPU;
      endcase
   end

   // FSM state, request bookkeeping and registered status outputs
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= CPU;
         pending_q      <= 1'b0;
         rc_seen_q      <= 1'b0;
         bc_seen_q      <= 1'b0;
         copy_q         <= 1'b0;
         copy_go_q      <= 1'b0;
         resume_q       <= 1'b0;
         cpu_rd_valid_q <= 1'b0;
         rc_rd_valid_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         // The request that starts a window is consumed; later ones wait
         if (state_q == CPU && state_d == DRAIN) begin
            pending_q <= 1'b0;
         end else begin
            pending_q <= pending_q | bus.copy_req;
         end
         if (state_q == FINISH) begin
            rc_seen_q <= 1'b0;
            bc_seen_q <= 1'b0;
         end else if (state_q == COPY) begin
            rc_seen_q <= rc_seen_q | bus.rc_done;
            bc_seen_q <= bc_seen_q | bus.bc_done;
         end
         copy_q         <= (state_d == COPY);
         copy_go_q      <= (state_q == DRAIN) && (state_d == COPY);
         resume_q       <= (state_d == FINISH);
         // Read tags follow the owner of the address one cycle earlier
         cpu_rd_valid_q <= (state_q == CPU) || (state_q == DRAIN);
         rc_rd_valid_q  <= (state_q == COPY);
      end
   end

   // Read port routing
   always_comb begin
      w_rd_owner = rd_owner(state_q);
      w_rd_addr  = bus.cpu_rd_addr;
      if (w_rd_owner == OWN_RC) begin
         w_rd_addr = bus.rc_rd_addr;
      end
   end

   // Write port routing; writes from a non-owner are dropped, never buffered
   always_comb begin
      w_wr_owner = wr_owner(state_q);
      w_we       = 1'b0;
      w_wr_addr  = bus.cpu_wr_addr;
      w_wr_data  = bus.cpu_wr_data;
      case (w_wr_owner)
         OWN_CPU: w_we = bus.cpu_we;
         OWN_BC: begin
            w_we      = bus.bc_we;
            w_wr_addr = bus.bc_wr_addr;
            w_wr_data = bus.bc_wr_data;
         end
         default: ;
      endcase
   end

   assign bus.mem_rd_addr  = w_rd_addr;
   assign bus.mem_we       = w_we;
   assign bus.mem_wr_addr  = w_wr_addr;
   assign bus.mem_wr_data  = w_wr_data;
   assign bus.cpu_rd_valid = cpu_rd_valid_q;
   assign bus.rc_rd_valid  = rc_rd_valid_q;
   assign bus.copy         = copy_q;
   assign bus.copy_go      = copy_go_q;
   assign bus.resume       = resume_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_dmem_arbiter                                        |
// | Description : Self-checking bench for dmem_arbiter: mux vector table,|
// |               read-tag scoreboard and timed copy-window sequences.   |
// |               Watchdog expectations follow DMEM_ARB_WDOG_EN.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;
   localparam int AW   = 13;
   localparam int WDOG = 64;
   localparam int S_CPU = 0, S_DRAIN = 1, S_COPY = 2, S_FINISH = 3;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   dmem_arbiter_if #(.AW(AW)) bus ();

   dmem_arbiter #(
      .DATA_ADDR_WIDTH (AW),
      .WDOG_CYCLES     (WDOG)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int   total = 0;
   int   bad   = 0;
   logic exp_wdog = 1'b0;

   typedef struct {
      logic cpu_rd;
      logic rc_rd;
   } tag_t;
   tag_t sb[$];

   typedef struct {
      logic          in_copy;
      logic          cpu_we;
      logic [AW-1:0] cpu_wa;
      logic [15:0]   cpu_wd;
      logic          bc_we;
      logic [AW-1:0] bc_wa;
      logic [15:0]   bc_wd;
      logic [AW-1:0] cpu_ra;
      logic [AW-1:0] rc_ra;
      logic          exp_we;
      logic [AW-1:0] exp_wa;
      logic [15:0]   exp_wd;
      logic [AW-1:0] exp_ra;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive_defaults();
      bus.copy_req    = 1'b0;
      bus.cpu_halted  = 1'b0;
      bus.cpu_rd_addr = 13'h0111;
      bus.cpu_we      = 1'b1;
      bus.cpu_wr_addr = 13'h0333;
      bus.cpu_wr_data = 16'hC0C0;
      bus.rc_rd_addr  = 13'h0222;
      bus.rc_done     = 1'b0;
      bus.bc_we       = 1'b1;
      bus.bc_wr_addr  = 13'h0444;
      bus.bc_wr_data  = 16'hB0B0;
      bus.bc_done     = 1'b0;
   endtask

   // One cycle in expected state st: check muxing/status now, push the
   // read tag the memory should return, clock, then pop and compare it.
   task automatic cyc(input int st, input logic go);
      tag_t t;
      #1;
      check("copy",     bus.copy,     st == S_COPY);
      check("copy_go",  bus.copy_go,  go);
      check("resume",   bus.resume,   st == S_FINISH);
      check("wdog_err", bus.wdog_err, exp_wdog);
      case (st)
         S_CPU: begin
            check("cpu mem_we",      bus.mem_we,      bus.cpu_we);
            check("cpu mem_wr_addr", bus.mem_wr_addr, bus.cpu_wr_addr);
            check("cpu mem_wr_data", bus.mem_wr_data, bus.cpu_wr_data);
            check("cpu mem_rd_addr", bus.mem_rd_addr, bus.cpu_rd_addr);
         end
         S_DRAIN: begin
            check("drain mem_we",      bus.mem_we,      1'b0);
            check("drain mem_rd_addr", bus.mem_rd_addr, bus.cpu_rd_addr);
         end
         S_COPY: begin
            check("copy mem_we",      bus.mem_we,      bus.bc_we);
            check("copy mem_wr_addr", bus.mem_wr_addr, bus.bc_wr_addr);
            check("copy mem_wr_data", bus.mem_wr_data, bus.bc_wr_data);
            check("copy mem_rd_addr", bus.mem_rd_addr, bus.rc_rd_addr);
         end
         default: check("finish mem_we", bus.mem_we, 1'b0);
      endcase
      t.cpu_rd = (st == S_CPU) || (st == S_DRAIN);
      t.rc_rd  = (st == S_COPY);
      sb.push_back(t);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: no expected read tag queued");
      end else begin
         t = sb.pop_front();
         check("cpu_rd_valid", bus.cpu_rd_valid, t.cpu_rd);
         check("rc_rd_valid",  bus.rc_rd_valid,  t.rc_rd);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int st;
      vecs[0] = '{1'b0, 1'b1, 13'h0001, 16'h1111, 1'b0, 13'h0100, 16'h2222, 13'h0005, 13'h0020, 1'b1, 13'h0001, 16'h1111, 13'h0005};
      vecs[1] = '{1'b0, 1'b0, 13'h0002, 16'h1212, 1'b1, 13'h0010, 16'hAAAA, 13'h0006, 13'h0020, 1'b0, 13'h0000, 16'h0000, 13'h0006};
      vecs[2] = '{1'b0, 1'b1, 13'h1FFF, 16'hFFFF, 1'b1, 13'h0010, 16'h5555, 13'h1FFF, 13'h0021, 1'b1, 13'h1FFF, 16'hFFFF, 13'h1FFF};
      vecs[3] = '{1'b0, 1'b0, 13'h0000, 16'h0000, 1'b0, 13'h0000, 16'h0000, 13'h0000, 13'h0022, 1'b0, 13'h0000, 16'h0000, 13'h0000};
      vecs[4] = '{1'b1, 1'b1, 13'h0003, 16'h3333, 1'b1, 13'h0044, 16'h4444, 13'h0005, 13'h0020, 1'b1, 13'h0044, 16'h4444, 13'h0020};
      vecs[5] = '{1'b1, 1'b1, 13'h0004, 16'h3434, 1'b0, 13'h0045, 16'h4545, 13'h0005, 13'h0021, 1'b0, 13'h0000, 16'h0000, 13'h0021};
      vecs[6] = '{1'b1, 1'b0, 13'h0005, 16'h3535, 1'b1, 13'h1ABC, 16'hC0DE, 13'h0007, 13'h1FFF, 1'b1, 13'h1ABC, 16'hC0DE, 13'h1FFF};
      vecs[7] = '{1'b1, 1'b0, 13'h0006, 16'h3636, 1'b0, 13'h0000, 16'h0000, 13'h0005, 13'h0000, 1'b0, 13'h0000, 16'h0000, 13'h0000};

      // Reset held 3 cycles with a CPU write pending
      drive_defaults();
      bus.cpu_wr_addr = 13'h0033;
      bus.cpu_wr_data = 16'hBEEF;
      bus.cpu_rd_addr = 13'h0007;
      resetn = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("rst copy",         bus.copy,         1'b0);
         check("rst copy_go",      bus.copy_go,      1'b0);
         check("rst resume",       bus.resume,       1'b0);
         check("rst cpu_rd_valid", bus.cpu_rd_valid, 1'b0);
         check("rst rc_rd_valid",  bus.rc_rd_valid,  1'b0);
         check("rst wdog_err",     bus.wdog_err,     1'b0);
         check("rst mem_we",       bus.mem_we,       1'b1);
         check("rst mem_wr_addr",  bus.mem_wr_addr,  13'h0033);
         check("rst mem_wr_data",  bus.mem_wr_data,  16'hBEEF);
         check("rst mem_rd_addr",  bus.mem_rd_addr,  13'h0007);
      end
      resetn = 1'b1;
      drive_defaults();

      // Mux table: CPU-owned vectors, then a window opened into COPY
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            bus.copy_req   = 1'b1;
            bus.cpu_halted = 1'b1;
            cyc(S_CPU, 1'b0);
            bus.copy_req    = 1'b0;
            bus.cpu_rd_addr = 13'h0005;
            cyc(S_DRAIN, 1'b0);
         end
         bus.cpu_we      = vecs[i].cpu_we;
         bus.cpu_wr_addr = vecs[i].cpu_wa;
         bus.cpu_wr_data = vecs[i].cpu_wd;
         bus.bc_we       = vecs[i].bc_we;
         bus.bc_wr_addr  = vecs[i].bc_wa;
         bus.bc_wr_data  = vecs[i].bc_wd;
         bus.cpu_rd_addr = vecs[i].cpu_ra;
         bus.rc_rd_addr  = vecs[i].rc_ra;
         #1;
         check($sformatf("vec%0d mem_we", i),      bus.mem_we,      vecs[i].exp_we);
         check($sformatf("vec%0d mem_rd_addr", i), bus.mem_rd_addr, vecs[i].exp_ra);
         if (vecs[i].exp_we) begin
            check($sformatf("vec%0d mem_wr_addr", i), bus.mem_wr_addr, vecs[i].exp_wa);
            check($sformatf("vec%0d mem_wr_data", i), bus.mem_wr_data, vecs[i].exp_wd);
         end
         cyc(vecs[i].in_copy ? S_COPY : S_CPU, i == 4);
      end
      // Both done pulses in the same COPY cycle
      bus.rc_done = 1'b1;
      bus.bc_done = 1'b1;
      cyc(S_COPY, 1'b0);
      bus.rc_done = 1'b0;
      bus.bc_done = 1'b0;
      cyc(S_FINISH, 1'b0);
      cyc(S_CPU, 1'b0);

      // Nominal window with a request queued during COPY; the second
      // window gets both done pulses in its copy_go cycle
      drive_defaults();
      bus.cpu_halted = 1'b1;
      for (int k = 0; k <= 20; k++) begin
         bus.copy_req    = (k == 0) || (k == 5);
         bus.rc_done     = (k == 10) || (k == 18);
         bus.bc_done     = (k == 14) || (k == 18);
         bus.cpu_rd_addr = 13'(k);
         bus.rc_rd_addr  = 13'(13'h0100 + k);
         st = (k == 0)  ? S_CPU   : (k == 1)  ? S_DRAIN :
              (k <= 14) ? S_COPY  : (k == 15) ? S_FINISH :
              (k == 16) ? S_CPU   : (k == 17) ? S_DRAIN :
              (k == 18) ? S_COPY  : (k == 19) ? S_FINISH : S_CPU;
         cyc(st, (k == 2) || (k == 18));
      end

      // Request while the CPU is not halted; bc_done before rc_done
      drive_defaults();
      for (int k = 0; k <= 26; k++) begin
         bus.copy_req   = (k == 0);
         bus.cpu_halted = (k >= 20);
         bus.bc_done    = (k == 23);
         bus.rc_done    = (k == 24);
         st = (k <= 20) ? S_CPU : (k == 21) ? S_DRAIN :
              (k <= 24) ? S_COPY : (k == 25) ? S_FINISH : S_CPU;
         cyc(st, k == 22);
      end

      // rc_done withheld
      drive_defaults();
      bus.cpu_halted = 1'b1;
`ifdef DMEM_ARB_WDOG_EN
      for (int k = 0; k <= 70; k++) begin
         bus.copy_req = (k == 0);
         bus.bc_done  = (k == 3);
         exp_wdog     = (k >= 66);
         st = (k == 0) ? S_CPU : (k == 1) ? S_DRAIN :
              (k <= 65) ? S_COPY : (k == 66) ? S_FINISH : S_CPU;
         cyc(st, k == 2);
      end
      resetn = 1'b0;
      @(posedge clk);
      #1;
      check("wdog_err cleared by reset", bus.wdog_err, 1'b0);
      resetn   = 1'b1;
      exp_wdog = 1'b0;
`else
      for (int k = 0; k <= 83; k++) begin
         bus.copy_req = (k == 0);
         bus.bc_done  = (k == 3);
         bus.rc_done  = (k == 81);
         st = (k == 0) ? S_CPU : (k == 1) ? S_DRAIN :
              (k <= 81) ? S_COPY : (k == 82) ? S_FINISH : S_CPU;
         cyc(st, k == 2);
      end
`endif

      // Reset in the middle of a window aborts it without a resume
      drive_defaults();
      bus.cpu_halted = 1'b1;
      bus.copy_req   = 1'b1;
      cyc(S_CPU, 1'b0);
      bus.copy_req = 1'b0;
      cyc(S_DRAIN, 1'b0);
      cyc(S_COPY, 1'b1);
      cyc(S_COPY, 1'b0);
      resetn      = 1'b0;
      bus.rc_done = 1'b1;
      bus.bc_done = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check("abort resume",       bus.resume,       1'b0);
         check("abort copy",         bus.copy,         1'b0);
         check("abort rc_rd_valid",  bus.rc_rd_valid,  1'b0);
         check("abort cpu_rd_valid", bus.cpu_rd_valid, 1'b0);
      end
      resetn = 1'b1;
      drive_defaults();
      cyc(S_CPU, 1'b0);
      cyc(S_CPU, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
